diff_sweep_ctrl: RTL and testbench
==================================

// Module: diff_sweep_ctrl
// PURPOSE
//  Sequencer for the three-memory frame comparator (mem1 = frame A, mem2 = frame B, mem3 = diff frame).
//  - Owns the shared address bus and all three write enables.
//  - LOAD job: streams one frame of pixels into mem1 or mem2.
//  - COMPARE job: sweeps every address so mem3 captures the per-channel diff pixel, and counts differing pixels.
// PARAMETERS
//  ADDR_W    19      width of shared memory address
//  PIX_W     24      pixel width (3 x 8-bit channels)
//  NPIX      307200  pixels per frame; addresses 0..NPIX-1
//  RD_LAT    1       posedges from address driven to q1/q2 valid (1 = registered address, unregistered q)
// PORTS
//  clk         in   1        single clock, all state on posedge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        job request, sampled only in IDLE
//  mode        in   1        with start: 0 = LOAD, 1 = COMPARE
//  load_sel    in   1        with start, LOAD only: 0 = mem1, 1 = mem2
//  abort       in   1        terminates the running job at the next posedge
//  in_valid    in   1        LOAD stream pixel valid
//  in_data     in   PIX_W    LOAD stream pixel
//  in_ready    out  1        LOAD stream ready
//  q1          in   PIX_W    mem1 read data
//  q2          in   PIX_W    mem2 read data
//  address     out  ADDR_W   shared address to mem1/mem2/mem3
//  wren1       out  1        mem1 write enable
//  wren2       out  1        mem2 write enable
//  wren3       out  1        mem3 write enable
//  data1       out  PIX_W    write data to mem1 and mem2
//  busy        out  1        high in any non-IDLE state
//  done        out  1        one-cycle pulse when a job ends, normally or by abort
//  aborted     out  1        level, valid with done, held until next start
//  diff_count  out  ADDR_W+1 pixels with >=1 differing channel, held until next COMPARE start
// BEHAVIOUR
//  Reset: state = IDLE; all outputs 0 (address, wren*, data1, in_ready, busy, done, aborted, diff_count).
//  State IDLE:
//   - On start & mode=0: latch load_sel, address=0, go to LOAD.
//   - On start & mode=1: address=0, diff_count=0, go to CMP_RD.
//  State LOAD:
//   - in_ready = 1.
//   - On in_valid & in_ready: data1 <= in_data and wren(sel) <= 1 for exactly the next cycle; address advances after that write cycle.
//   - Throughput is 1 pixel per 2 cycles; in_ready is 0 during the write cycle.
//   - After the write to NPIX-1: go to FIN; address is not incremented past NPIX-1.
//  State CMP_RD:
//   - Hold address for RD_LAT cycles (phase counter), then go to CMP_WR.
//  State CMP_WR:
//   - Hold address; wren3 = 1 for 1 cycle.
//   - The comparator forms data3 on the preceding negedge from q1/q2 at this address.
//   - In the same cycle, diff_count += (q1 != q2).
//   - If address == NPIX-1: go to FIN; else address++ and return to CMP_RD.
//   - Cost is RD_LAT+1 cycles per pixel.
//  State FIN:
//   - done = 1 for one cycle; all wren = 0; go to IDLE.
//  Abort:
//   - In LOAD, CMP_RD or CMP_WR: go to FIN next posedge with aborted = 1; all wren forced 0 that cycle.
//   - A write already in flight is dropped.
//   - abort in IDLE or FIN is ignored.
//  Simultaneous events:
//   - start & abort in IDLE: start wins.
//   - abort & last write in the same cycle: abort wins, the write is dropped and aborted = 1.
//  Enable exclusivity: at most one wren high in any cycle; wren never high in IDLE or FIN.
//  Width: diff_count saturates at NPIX; the address compare uses NPIX-1 at ADDR_W width.
//  Reset mid-job: asserting rst at any time returns to the reset values immediately (asynchronous); no done pulse is produced.
// STRUCTURE
//  Shared package (cmp_pkg): state encoding (IDLE, LOAD, CMP_RD, CMP_WR, FIN), ADDR_W, PIX_W, NPIX, MODE_LOAD/MODE_CMP constants.
//  Sub-module: addr_sweep_cnt (address counter with clear, increment and terminal flag at NPIX-1).
//  The FSM and diff counter live in the top module.
// TESTING
//  Bench uses NPIX=8, RD_LAT=1, with behavioural mem models and the comparator instance.
//  1. LOAD, sel=0, 8 back-to-back pixels 0x000001..0x000008
//     -> mem1[0..7] holds them; wren1 pulses 8 times; wren2 = wren3 = 0; one done; aborted = 0.
//  2. mem1 == mem2 (all 0x112233), COMPARE
//     -> mem3[0..7] = 0x808080; diff_count = 0; done exactly 16 cycles after start accepted.
//  3. mem2[3] = 0x11FF33, rest equal, COMPARE
//     -> mem3[3] = 0x802280; all other entries 0x808080; diff_count = 1.
//  4. in_valid deasserted for 5 cycles mid-LOAD
//     -> no write during the gap; address holds; all 8 pixels land at the correct addresses.
//  5. abort at address 4 in CMP_WR
//     -> no wren3 that cycle; done & aborted; mem3[4..7] unchanged; diff_count reflects addresses 0..3.
//  6. rst pulsed mid-COMPARE, then a new COMPARE
//     -> all outputs 0 immediately, no done pulse; the rerun completes with correct diff_count.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and default sizes for the three-memory frame diff sequencer.
package cmp_pkg;

   localparam int ADDR_W = 19;
   localparam int PIX_W  = 24;
   localparam int NPIX   = 307200;
   localparam int RD_LAT = 1;

   localparam logic MODE_LOAD = 1'b0;
   localparam logic MODE_CMP  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CMP_RD,
      CMP_WR,
      FIN
   } state_t;

endpackage

// File: rtl/addr_sweep_cnt.sv
// Shared frame address counter: clear, step, and terminal flag at NPIX-1.
module addr_sweep_cnt #(
   parameter int ADDR_W = 19,
   parameter int NPIX   = 307200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);

   assign last = (addr == LAST_A);

   // Never steps past the last pixel, so the bus parks on NPIX-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr <= '0;
      else if (clr)
         addr <= '0;
      else if (inc && !last)
         addr <= addr + ADDR_W'(1);
   end

endmodule

// File: rtl/diff_sweep_ctrl.sv
// Sequencer for the frame comparator: loads mem1/mem2, sweeps mem3 diffs
// and counts differing pixels.
module diff_sweep_ctrl #(
   parameter int ADDR_W = cmp_pkg::ADDR_W,
   parameter int PIX_W  = cmp_pkg::PIX_W,
   parameter int NPIX   = cmp_pkg::NPIX,
   parameter int RD_LAT = cmp_pkg::RD_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic              load_sel,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [PIX_W-1:0]  in_data,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  q1,
   input  logic [PIX_W-1:0]  q2,
   output logic [ADDR_W-1:0] address,
   output logic              wren1,
   output logic              wren2,
   output logic              wren3,
   output logic [PIX_W-1:0]  data1,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [ADDR_W:0]   diff_count
);

   import cmp_pkg::*;

   localparam int CW   = ADDR_W + 1;
   localparam int PH_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(RD_LAT - 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(NPIX);

   state_t          state;
   logic            sel;
   logic [PH_W-1:0] phase;
   logic            rdy_r;
   logic            w1_r;
   logic            w2_r;
   logic            w3_r;
   logic            kill;
   logic            clr;
   logic            inc;
   logic            last;
   logic            ld_wr;

   assign ld_wr = w1_r | w2_r;
   assign kill  = abort &
                  (state == LOAD || state == CMP_RD || state == CMP_WR);

   // Abort masks the in-flight write and the handshake in its own cycle.
   assign wren1    = w1_r & ~kill;
   assign wren2    = w2_r & ~kill;
   assign wren3    = w3_r & ~kill;
   assign in_ready = rdy_r & ~kill;
   assign busy     = (state != IDLE);

   assign clr = (state == IDLE) & start;
   assign inc = ~kill &
                (((state == LOAD) & ld_wr) | (state == CMP_WR));

   addr_sweep_cnt #(
      .ADDR_W (ADDR_W),
      .NPIX   (NPIX)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (inc),
      .addr (address),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= 1'b0;
         phase      <= '0;
         rdy_r      <= 1'b0;
         w1_r       <= 1'b0;
         w2_r       <= 1'b0;
         w3_r       <= 1'b0;
         data1      <= '0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         diff_count <= '0;
      end else if (kill) begin
         state   <= FIN;
         rdy_r   <= 1'b0;
         w1_r    <= 1'b0;
         w2_r    <= 1'b0;
         w3_r    <= 1'b0;
         done    <= 1'b1;
         aborted <= 1'b1;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  aborted <= 1'b0;
                  if (mode == MODE_LOAD) begin
                     sel   <= load_sel;
                     rdy_r <= 1'b1;
                     state <= LOAD;
                  end else begin
                     diff_count <= '0;
                     phase      <= '0;
                     state      <= CMP_RD;
                  end
               end
            end
            LOAD: begin
               if (ld_wr) begin
                  w1_r <= 1'b0;
                  w2_r <= 1'b0;
                  if (last) begin
                     rdy_r <= 1'b0;
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     rdy_r <= 1'b1;
                  end
               end else if (in_valid && rdy_r) begin
                  rdy_r <= 1'b0;
                  data1 <= in_data;
                  w1_r  <= ~sel;
                  w2_r  <= sel;
               end
            end
            CMP_RD: begin
               if (phase == PH_LAST) begin
                  w3_r  <= 1'b1;
                  state <= CMP_WR;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            CMP_WR: begin
               w3_r <= 1'b0;
               if (q1 != q2 && diff_count != CNT_MAX)
                  diff_count <= diff_count + CW'(1);
               if (last) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  phase <= '0;
                  state <= CMP_RD;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diff_sweep_ctrl.sv
// Directed bench for diff_sweep_ctrl with behavioural memories and comparator.
module tb_diff_sweep_ctrl;

   localparam int AW = 4;
   localparam int PW = 24;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic          load_sel = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          in_ready;
   logic [PW-1:0] q1;
   logic [PW-1:0] q2;
   logic [AW-1:0] address;
   logic          wren1;
   logic          wren2;
   logic          wren3;
   logic [PW-1:0] data1;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [AW:0]   diff_count;

   logic [PW-1:0] mem1 [N];
   logic [PW-1:0] mem2 [N];
   logic [PW-1:0] mem3 [N];
   logic [PW-1:0] ld_px [N];
   logic [AW-1:0] ra = '0;
   logic [PW-1:0] data3 = '0;

   int checks = 0;
   int failures = 0;
   int w1_cnt = 0;
   int w2_cnt = 0;
   int w3_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      logic [1:0]    m;
      logic [AW-1:0] a;
      logic [PW-1:0] d;
   } wr_t;
   wr_t sb [$];

   diff_sweep_ctrl #(
      .ADDR_W (AW),
      .PIX_W  (PW),
      .NPIX   (N),
      .RD_LAT (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .load_sel   (load_sel),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .q1         (q1),
      .q2         (q2),
      .address    (address),
      .wren1      (wren1),
      .wren2      (wren2),
      .wren3      (wren3),
      .data1      (data1),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .diff_count (diff_count)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] cmp_pix(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
      logic [PW-1:0] r;
      r = '0;
      for (int c = 0; c < 3; c++)
         r[c*8 +: 8] = (a[c*8 +: 8] == b[c*8 +: 8]) ? 8'h80 : a[c*8 +: 8];
      return r;
   endfunction

   function automatic void chk(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   // Registered-address memories, comparator output formed on negedge.
   always @(posedge clk) begin
      ra <= address;
      if (wren1) mem1[address[2:0]] <= data1;
      if (wren2) mem2[address[2:0]] <= data1;
      if (wren3) mem3[address[2:0]] <= data3;
   end

   assign q1 = mem1[ra[2:0]];
   assign q2 = mem2[ra[2:0]];

   always @(negedge clk) data3 <= cmp_pix(q1, q2);

   always @(negedge clk) begin
      wr_t        e;
      logic [1:0] m;
      if (done) done_cnt++;
      if (wren1 | wren2 | wren3) begin
         m = wren1 ? 2'd1 : (wren2 ? 2'd2 : 2'd3);
         if (wren1) w1_cnt++;
         if (wren2) w2_cnt++;
         if (wren3) w3_cnt++;
         chk("wren_onehot", 64'($countones({wren1, wren2, wren3})), 64'd1);
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_unexpected_write observed=%0d expected=none", m);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_mem", 64'(m), 64'(e.m));
            chk("wr_addr", 64'(address), 64'(e.a));
            if (m != 2'd3) chk("wr_data", 64'(data1), 64'(e.d));
         end
      end
   end

   task automatic clr_cnt();
      w1_cnt = 0;
      w2_cnt = 0;
      w3_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic go(input logic m, input logic s);
      start = 1'b1;
      mode = m;
      load_sel = s;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      assert (done === 1'b1) else begin
         failures++;
         $error("FAIL done_timeout observed=%0b expected=1", done);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [PW-1:0] px, output bit ok);
      in_valid = 1'b1;
      in_data = px;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic load_job(input logic s, input int gap_at);
      bit ok;
      int cyc;
      go(cmp_pkg::MODE_LOAD, s);
      for (int i = 0; i < N; i++) begin
         if (i == gap_at) begin
            repeat (2) @(posedge clk);
            #1;
            chk("gap_addr_early", 64'(address), 64'(gap_at));
            repeat (3) @(posedge clk);
            #1;
            chk("gap_addr_late", 64'(address), 64'(gap_at));
            chk("gap_writes", 64'(s ? w2_cnt : w1_cnt), 64'(gap_at));
         end
         sb.push_back(wr_t'{s ? 2'd2 : 2'd1, AW'(i), ld_px[i]});
         feed(ld_px[i], ok);
         chk("feed_accept", 64'(ok), 64'd1);
      end
      wait_done(cyc);
   endtask

   task automatic push_cmp(input int n);
      for (int a = 0; a < n; a++)
         sb.push_back(wr_t'{2'd3, AW'(a), '0});
   endtask

   initial begin
      int  cyc;
      bit  found;
      #3;
      chk("reset_outputs",
          64'({address, wren1, wren2, wren3, data1, in_ready,
               busy, done, aborted, diff_count}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: back-to-back load into mem1
      for (int i = 0; i < N; i++) ld_px[i] = PW'(i + 1);
      clr_cnt();
      load_job(1'b0, -1);
      for (int i = 0; i < N; i++)
         chk("t1_mem1", 64'(mem1[i]), 64'(i + 1));
      chk("t1_wren1_cnt", 64'(w1_cnt), 64'd8);
      chk("t1_wren23_cnt", 64'(w2_cnt + w3_cnt), 64'd0);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);
      chk("t1_aborted", 64'(aborted), 64'd0);
      chk("t1_sb_empty", 64'(sb.size()), 64'd0);

      // 2: identical frames
      for (int i = 0; i < N; i++) begin
         mem1[i] = 24'h112233;
         mem2[i] = 24'h112233;
         mem3[i] = '0;
      end
      clr_cnt();
      push_cmp(N);
      go(cmp_pkg::MODE_CMP, 1'b0);
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("t2_done_latency", 64'(cyc), 64'd16);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         chk("t2_mem3", 64'(mem3[i]), 64'h808080);
      chk("t2_diff_count", 64'(diff_count), 64'd0);
      chk("t2_wren3_cnt", 64'(w3_cnt), 64'd8);
      chk("t2_sb_empty", 64'(sb.size()), 64'd0);

      // 3: one differing pixel
      mem2[3] = 24'h11FF33;
      clr_cnt();
      push_cmp(N);
      go(cmp_pkg::MODE_CMP, 1'b0);
      wait_done(cyc);
      for (int i = 0; i < N; i++)
         chk("t3_mem3", 64'(mem3[i]),
             (i == 3) ? 64'h802280 : 64'h808080);
      chk("t3_diff_count", 64'(diff_count), 64'd1);
      chk("t3_done_cnt", 64'(done_cnt), 64'd1);

      // 4: load mem2 with a 5-cycle valid gap
      for (int i = 0; i < N; i++)
         ld_px[i] = (i == 1 || i == 3 || i == 4 || i == 6)
                    ? (24'h0A0B00 | PW'(i)) : 24'h112233;
      clr_cnt();
      load_job(1'b1, 3);
      for (int i = 0; i < N; i++)
         chk("t4_mem2", 64'(mem2[i]), 64'(ld_px[i]));
      chk("t4_wren2_cnt", 64'(w2_cnt), 64'd8);
      chk("t4_wren1_cnt", 64'(w1_cnt), 64'd0);

      // 5: abort during the write phase of address 4
      for (int i = 0; i < N; i++) mem3[i] = 24'hABCDEF;
      clr_cnt();
      push_cmp(4);
      go(cmp_pkg::MODE_CMP, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk);
         #1;
         if (wren3 && address == AW'(4)) found = 1'b1;
      end
      chk("t5_reach_addr4", 64'(found), 64'd1);
      abort = 1'b1;
      #1;
      chk("t5_wren3_masked", 64'(wren3), 64'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("t5_done", 64'(done), 64'd1);
      chk("t5_aborted", 64'(aborted), 64'd1);
      @(posedge clk);
      #1;
      chk("t5_idle", 64'(busy), 64'd0);
      chk("t5_aborted_held", 64'(aborted), 64'd1);
      for (int i = 0; i < N; i++)
         chk("t5_mem3", 64'(mem3[i]),
             (i < 4) ? 64'(cmp_pix(24'h112233, ld_px[i])) : 64'hABCDEF);
      chk("t5_diff_count", 64'(diff_count), 64'd2);
      chk("t5_sb_empty", 64'(sb.size()), 64'd0);

      // 6: reset mid-compare, then a clean rerun
      clr_cnt();
      push_cmp(N);
      go(cmp_pkg::MODE_CMP, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_reset_outputs",
          64'({address, wren1, wren2, wren3, data1, in_ready,
               busy, done, aborted, diff_count}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("t6_no_done", 64'(done_cnt), 64'd0);
      chk("t6_idle", 64'(busy), 64'd0);
      for (int i = 0; i < N; i++) mem3[i] = 24'hABCDEF;
      push_cmp(N);
      go(cmp_pkg::MODE_CMP, 1'b0);
      wait_done(cyc);
      for (int i = 0; i < N; i++)
         chk("t6_mem3", 64'(mem3[i]),
             64'(cmp_pix(24'h112233, ld_px[i])));
      chk("t6_diff_count", 64'(diff_count), 64'd4);
      chk("t6_aborted", 64'(aborted), 64'd0);
      chk("t6_done_cnt", 64'(done_cnt), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
